// File: rtl/uart_pkg.sv
// Shared types for the UART packet controller: sync byte, frame FSM states
// and the end-of-frame status record.
package uart_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LEN,
    PAYLOAD,
    CKSUM,
    DONE
  } state_t;

  typedef struct packed {
    logic ok;
    logic cksum;
    logic overrun;
    logic timeout;
  } frame_status_t;

endpackage

// File: rtl/uart_baud_gen.sv
// 16x-baud enable generator: free-running 0..DIV-1 counter, rx_tick on the
// terminal count.
module uart_baud_gen #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200
) (
  input  logic clk,
  input  logic rst,
  output logic rx_tick
);

  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int CW  = $clog2((DIV > 2) ? DIV : 2);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_baud_gen: DIV must be at least 2");
  end

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign rx_tick = (cnt == LAST);

endmodule

// File: rtl/uart_pkt_ctrl.sv
// Frames the UART receiver byte stream (SYNC, CMD, LEN, payload, CKSUM) into
// a command strobe, a valid/ready payload stream and an end-of-frame status.
module uart_pkt_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int BAUD          = 115200,
  parameter int TIMEOUT_TICKS = 320
) (
  input  logic       clk,
  input  logic       rst,
  output logic       rx_tick,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       enable,
  output logic       cmd_valid,
  output logic [7:0] cmd,
  output logic [7:0] len,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  input  logic       m_ready,
  output logic       done,
  output logic       done_ok,
  output logic       err_cksum,
  output logic       err_overrun,
  output logic       err_timeout
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  state_t        state, state_nxt;
  logic [7:0]    chk_q;
  logic [7:0]    rem_q;
  logic [TW-1:0] gap_q;
  logic          cksum_q, ovr_q, to_q;
  frame_status_t st;

  logic in_frame, start, to_hit, pl_byte, m_free;

  uart_baud_gen #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .rx_tick(rx_tick)
  );

  assign in_frame = state inside {CMD, LEN, PAYLOAD, CKSUM};
  assign start    = rx_valid && enable && (rx_data == SYNC_BYTE);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign to_hit   = in_frame && !rx_valid && (gap_q == TW'(TIMEOUT_TICKS));
  assign pl_byte  = (state == PAYLOAD) && rx_valid;
  assign m_free   = !m_valid || m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = start ? CMD : IDLE;
      CMD:        if (rx_valid) state_nxt = LEN;
      LEN:        if (rx_valid) state_nxt = (rx_data != 8'd0) ? PAYLOAD : CKSUM;
      PAYLOAD:    if (rx_valid && rem_q == 8'd1) state_nxt = CKSUM;
      CKSUM:      if (rx_valid) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
    if (to_hit) state_nxt = DONE;
  end

  // Frame datapath: checksum, remaining count, captured header, status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_q     <= '0;
      rem_q     <= '0;
      cmd       <= '0;
      len       <= '0;
      cmd_valid <= 1'b0;
      cksum_q   <= 1'b0;
      ovr_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      cmd_valid <= (state == LEN) && rx_valid;
      case (state)
        IDLE, DONE: if (start) begin
          chk_q   <= '0;
          cksum_q <= 1'b0;
          ovr_q   <= 1'b0;
          to_q    <= 1'b0;
        end
        CMD: if (rx_valid) begin
          cmd   <= rx_data;
          chk_q <= chk_q ^ rx_data;
        end
        LEN: if (rx_valid) begin
          len   <= rx_data;
          rem_q <= rx_data;
          chk_q <= chk_q ^ rx_data;
        end
        PAYLOAD: if (rx_valid) begin
          chk_q <= chk_q ^ rx_data;
          rem_q <= rem_q - 8'd1;
          if (!m_free) ovr_q <= 1'b1;
        end
        CKSUM: if (rx_valid) cksum_q <= (rx_data != chk_q);
        default: ;
      endcase
      if (to_hit) to_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        gap_q <= '0;
    else if (!in_frame || rx_valid) gap_q <= '0;
    else if (rx_tick)               gap_q <= gap_q + 1'b1;
  end

  // One-entry output register; never flushed by end of frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (pl_byte && m_free) begin
      m_valid <= 1'b1;
      m_data  <= rx_data;
      m_last  <= (rem_q == 8'd1);
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  assign st.cksum   = cksum_q;
  assign st.overrun = ovr_q;
  assign st.timeout = to_q;
  assign st.ok      = ~cksum_q & ~ovr_q & ~to_q;

  assign done        = (state == DONE);
  assign done_ok     = done & st.ok;
  assign err_cksum   = done & st.cksum;
  assign err_overrun = done & st.overrun;
  assign err_timeout = done & st.timeout;

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Scoreboard bench for uart_pkt_ctrl: expected commands, payload beats and
// frame status are queued as bytes are driven and popped as the DUT emits them.
module tb_uart_pkt_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_tick;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic       enable = 1'b1;
  logic       cmd_valid;
  logic [7:0] cmd, len;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready = 1'b1;
  logic       done, done_ok, err_cksum, err_overrun, err_timeout;

  always #5 clk = ~clk;

  uart_pkt_ctrl #(
    .CLK_HZ       (1_600_000),
    .BAUD         (10_000),
    .TIMEOUT_TICKS(320)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_tick    (rx_tick),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .enable     (enable),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .len        (len),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .done       (done),
    .done_ok    (done_ok),
    .err_cksum  (err_cksum),
    .err_overrun(err_overrun),
    .err_timeout(err_timeout)
  );

  typedef struct {logic [7:0] d; logic l;} beat_t;
  typedef struct {logic [7:0] c; logic [7:0] n;} hdr_t;
  typedef struct {logic ok; logic ck; logic ov; logic to;} st_t;

  beat_t q_m[$];
  hdr_t  q_cmd[$];
  st_t   q_done[$];

  int n_chk = 0;
  int n_pass = 0;
  int ticks_since = 0;
  int done_ticks = -1;
  int n_done = 0, n_cmdv = 0, n_mv = 0;
  beat_t e_m;
  hdr_t  e_c;
  st_t   e_s;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Monitor: sampled mid-cycle; inputs change only 2 time units after posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) ticks_since = 0;
      else if (rx_tick) ticks_since++;
      if (m_valid) n_mv++;
      if (m_valid && m_ready) begin
        if (q_m.size() == 0) chk("unexp_m", 1, 0);
        else begin
          e_m = q_m.pop_front();
          chk("m_data", m_data, e_m.d);
          chk("m_last", m_last, e_m.l);
        end
      end
      if (cmd_valid) begin
        n_cmdv++;
        if (q_cmd.size() == 0) chk("unexp_cmd", 1, 0);
        else begin
          e_c = q_cmd.pop_front();
          chk("cmd", cmd, e_c.c);
          chk("len", len, e_c.n);
        end
      end
      if (done) begin
        n_done++;
        done_ticks = ticks_since;
        if (q_done.size() == 0) chk("unexp_done", 1, 0);
        else begin
          e_s = q_done.pop_front();
          chk("done_ok", done_ok, e_s.ok);
          chk("err_cksum", err_cksum, e_s.ck);
          chk("err_overrun", err_overrun, e_s.ov);
          chk("err_timeout", err_timeout, e_s.to);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #2;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #2;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic push_m(input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d; b.l = l;
    q_m.push_back(b);
  endtask

  task automatic push_cmd(input logic [7:0] c, input logic [7:0] n);
    hdr_t h;
    h.c = c; h.n = n;
    q_cmd.push_back(h);
  endtask

  task automatic push_done(input logic ok, input logic ck, input logic ov, input logic to);
    st_t s;
    s.ok = ok; s.ck = ck; s.ov = ov; s.to = to;
    q_done.push_back(s);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (q_done.size() != 0 && n < budget) begin @(posedge clk); n++; end
    chk(tag, (n < budget), 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((q_done.size() != 0 || q_cmd.size() != 0 || q_m.size() != 0) && n < budget) begin
      @(posedge clk); n++;
    end
    chk(tag, (n < budget), 1);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) @(negedge clk);
    chk("rst_tick", rx_tick, 0);
    chk("rst_cmdv", cmd_valid, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_len", len, 0);
    chk("rst_mv", m_valid, 0);
    chk("rst_md", m_data, 0);
    chk("rst_ml", m_last, 0);
    chk("rst_done", done, 0);
    chk("rst_ok", done_ok, 0);
    chk("rst_errs", {err_cksum, err_overrun, err_timeout}, 0);

    // Divider: tick on every 10th cycle, first at cycle 9.
    @(negedge clk); rst = 1'b0;
    for (int n = 0; n < 30; n++) begin
      #1 chk("tick", rx_tick, ((n % 10) == 9));
      @(negedge clk);
    end

    // Good frame with leading junk.
    push_cmd(8'h10, 8'h03);
    push_m(8'h01, 1'b0); push_m(8'h02, 1'b0); push_m(8'h03, 1'b1);
    push_done(1, 0, 0, 0);
    send(8'h00); send(8'hFF); send(8'hA5); send(8'h10); send(8'h03);
    send(8'h01); send(8'h02); send(8'h03); send(8'h13);
    wait_drain("good_drain", 200);

    // Zero length, good then bad checksum.
    push_cmd(8'h22, 8'h00); push_done(1, 0, 0, 0);
    base = n_mv;
    send(8'hA5); send(8'h22); send(8'h00); send(8'h22);
    wait_drain("zl_drain", 200);
    chk("zl_no_m", n_mv - base, 0);
    push_cmd(8'h22, 8'h00); push_done(0, 1, 0, 0);
    send(8'hA5); send(8'h22); send(8'h00); send(8'h23);
    wait_drain("bad_drain", 200);

    // Overrun: consumer stalled, 02 and 03 dropped.
    m_ready = 1'b0;
    push_cmd(8'h10, 8'h03); push_m(8'h01, 1'b0); push_done(0, 0, 1, 0);
    send(8'hA5); send(8'h10); send(8'h03); send(8'h01);
    send(8'h02); send(8'h03); send(8'h13);
    wait_done("ovr_done", 200);
    @(negedge clk);
    chk("ovr_hold_v", m_valid, 1);
    chk("ovr_hold_d", m_data, 8'h01);
    @(posedge clk); #2 m_ready = 1'b1;
    wait_drain("ovr_drain", 200);
    chk("ovr_empty", m_valid, 0);

    // Timeout after CMD, then a normal frame.
    push_done(0, 0, 0, 1);
    send(8'hA5); send(8'h10);
    wait_done("to_done", 5000);
    chk("to_ticks", done_ticks, 320);
    push_cmd(8'h22, 8'h00); push_done(1, 0, 0, 0);
    send(8'hA5); send(8'h22); send(8'h00); send(8'h22);
    wait_drain("to_next", 200);

    // Disabled: whole frame ignored.
    base = n_done + n_cmdv + n_mv;
    enable = 1'b0;
    send(8'hA5); send(8'h10); send(8'h00); send(8'h10);
    enable = 1'b1;
    repeat (20) @(posedge clk);
    chk("dis_quiet", n_done + n_cmdv + n_mv - base, 0);

    // Reset mid-payload: frame discarded, next frame clean.
    m_ready = 1'b0;
    push_cmd(8'h10, 8'h03);
    send(8'hA5); send(8'h10); send(8'h03); send(8'h01); send(8'h02);
    base = n_done;
    @(posedge clk); #2 rst = 1'b1;
    #1 chk("rst_mid_mv", m_valid, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    repeat (20) @(posedge clk);
    chk("rst_no_done", n_done - base, 0);
    push_cmd(8'h10, 8'h03);
    push_m(8'h01, 1'b0); push_m(8'h02, 1'b0); push_m(8'h03, 1'b1);
    push_done(1, 0, 0, 0);
    send(8'hA5); send(8'h10); send(8'h03);
    send(8'h01); send(8'h02); send(8'h03); send(8'h13);
    wait_drain("post_rst", 200);

    chk("q_m_empty", q_m.size(), 0);
    chk("q_cmd_empty", q_cmd.size(), 0);
    chk("q_done_empty", q_done.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_pkt_ctrl.md
Name: uart_pkt_ctrl

Overview:
Controller that sits directly above the 16x-oversampling UART receiver. It generates the receiver's rx_tick enable, and turns the receiver's raw byte stream into framed commands for the JPEG encoder's host path.
Frame format on the wire: SYNC(0xA5), CMD, LEN, LEN payload bytes, CKSUM.
- CKSUM is the XOR of CMD, LEN and all payload bytes.
- Payload is forwarded downstream through a one-entry valid/ready register.
- Frame status is reported at the end of every frame.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz.
BAUD, 115200, line rate. DIV = CLK_HZ/(BAUD*16), integer division, DIV >= 2 required (elaboration assertion).
TIMEOUT_TICKS, 320, maximum inter-byte gap inside a frame, counted in rx_tick pulses (20 bit times).

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
rx_tick  output  1  16x-baud enable to the receiver, one-cycle pulse
rx_valid  input  1  receiver byte strobe, one cycle
rx_data  input  8  receiver byte, valid with rx_valid
enable  input  1  frame acceptance enable
cmd_valid  output  1  one-cycle pulse when CMD and LEN have been captured
cmd  output  8  captured command, held until the next frame's cmd_valid
len  output  8  captured payload length, held likewise
m_valid  output  1  payload byte available
m_data  output  8  payload byte
m_last  output  1  marks the final payload byte of the frame
m_ready  input  1  downstream accept
done  output  1  one-cycle end-of-frame pulse
done_ok  output  1  valid with done: checksum matched, no overrun, no timeout
err_cksum  output  1  valid with done
err_overrun  output  1  valid with done
err_timeout  output  1  valid with done

Behaviour:
Reset:
- All outputs 0. FSM goes to IDLE; divider, gap counter, checksum and overrun flag are cleared.
- Reset mid-frame discards the frame: no done pulse, m_valid drops immediately.

Baud divider:
- Counter runs 0..DIV-1 continuously, independent of enable.
- rx_tick is high in the cycle the counter equals DIV-1; the counter then wraps to 0.

FSM states and transitions:
- IDLE: on rx_valid & enable & rx_data==0xA5, go to CMD and clear checksum to 0. Any other byte, or any byte while enable=0, is ignored. enable is sampled only here; a frame already in progress always completes.
- CMD: on rx_valid, capture cmd, XOR the byte into checksum, go to LEN.
- LEN: on rx_valid:
  - capture len, XOR into checksum, set remaining count = rx_data, pulse cmd_valid in the following cycle;
  - go to PAYLOAD if rx_data != 0, else go to CKSUM.
- PAYLOAD: on rx_valid:
  - XOR the byte into checksum and decrement the remaining count;
  - if the output register is free, or being accepted this cycle (m_valid & m_ready), load it: m_valid=1, m_data=byte, m_last=(remaining==1);
  - otherwise drop the byte and set the overrun flag;
  - when remaining reaches 0, go to CKSUM.
  - A 0xA5 byte here is ordinary data.
- CKSUM: on rx_valid, err_cksum = (rx_data != checksum), go to DONE.
- DONE (one cycle):
  - pulse done, with done_ok = ~err_cksum & ~overrun, and err_overrun = overrun flag;
  - then go to IDLE;
  - an rx_valid arriving in this cycle is evaluated as IDLE would evaluate it.

Output register:
- m_valid clears on m_ready when no new byte loads in the same cycle.
- The register may still hold the last byte after done. It is never flushed by done.
- Payload is forwarded before the checksum is verified; the consumer discards the frame when done_ok=0.

Timeout:
- Gap counter increments on rx_tick in every state except IDLE/DONE, and clears on rx_valid.
- On reaching TIMEOUT_TICKS: go to DONE with err_timeout=1 and done_ok=0. err_cksum=0 unless it was already set. Partial payload already forwarded stays forwarded.
- Counter width is $clog2(TIMEOUT_TICKS+1).

Simultaneous events:
- rx_valid and timeout expiry in the same cycle: the byte wins and the gap counter clears.

Decomposition:
- Package uart_pkg holds: SYNC_BYTE=8'hA5; the state enum {IDLE, CMD, LEN, PAYLOAD, CKSUM, DONE}; and a frame-status struct {ok, cksum, overrun, timeout}.
- Sub-module uart_baud_gen contains the DIV counter and rx_tick (parameters CLK_HZ, BAUD). The receiver is instantiated by the parent, not inside this block.

Test Plan:
Bench parameters: CLK_HZ=1_600_000, BAUD=10_000 (DIV=10). Bytes are driven as rx_valid strobes.
1. Divider: after reset release, rx_tick is high every 10th cycle, first at cycle 9; never two consecutive high cycles.
2. Good frame: bytes 0x00 0xFF A5 10 03 01 02 03 13 with m_ready=1 -> cmd_valid once with cmd=0x10, len=3; m_data 01,02,03 with m_last only on 03; done=1, done_ok=1, all err=0.
3. Zero length and bad checksum:
   - A5 22 00 22 -> no m_valid, done_ok=1.
   - A5 22 00 23 -> done_ok=0, err_cksum=1.
4. Overrun: A5 10 03 01 02 03 13 with m_ready=0 -> m_data holds 01; bytes 02 and 03 are dropped; done_ok=0, err_overrun=1, err_cksum=0.
5. Timeout: A5 10 then silence -> done fires exactly 320 rx_ticks after the 0x10 strobe, with err_timeout=1. A following A5 frame is received normally.
6. Disable and reset:
   - enable=0 during A5 10 00 10 -> no outputs.
   - Assert rst mid-payload of frame 2 -> m_valid=0, no done pulse; the next full frame passes.
